ws2812_chain_driver: RTL and testbench
======================================

Name: ws2812_chain_driver

Overview:
Parametrised successor to the fixed 16-LED, 24-bit WS2812B line driver. Serialises a frame of NUM_LEDS pixels from an external pixel store onto one NRZ data line, then holds the latch/reset gap. Adds RGB/RGBW pixel width, clock-count timing parameters, global brightness scaling, a synchronous reset, and a busy/done handshake. Sits between the frame buffer (BRAM, 1-cycle read latency) and the LED-strip pin.

Parameters:
NUM_LEDS, 16, pixels per frame (>=1)
BYTES_PER_LED, 3, 3 = GRB, 4 = GRBW (other values illegal)
BIT_CLKS, 63, clocks per encoded bit
T1H_CLKS, 39, high time of a '1' code, in clocks (< BIT_CLKS)
T0H_CLKS, 19, high time of a '0' code, in clocks (< T1H_CLKS)
RESET_CLKS, 2600, low clocks of the latch gap after the last bit

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low
start  in  1  frame request; acted on only at a rising edge while Idle
brightness  in  8  global scale, sampled at frame start
pixel_addr  out  $clog2(NUM_LEDS) (min 1)  pixel index requested from store
pixel_data  in  8*BYTES_PER_LED  {G,R,B[,W]}; valid 1 cycle after pixel_addr
busy  out  1  high from frame accept to end of latch gap
done  out  1  1-cycle pulse when latch gap completes
leds_line  out  1  registered NRZ output to strip

Behaviour:
- Reset (rst_n=0 at clk edge): leds_line=0, busy=0, done=0, pixel_addr=0, state Idle, all counters 0, start-edge history cleared to 1 (a start already high at reset release is not a rising edge). Takes priority over every other event, including mid-bit and mid-gap; line is low from the next clock.
- States: Idle -> Fetch -> Send -> Latch -> Idle.
- Idle: leds_line=0. On start rising edge: busy=1, brightness latched, pixel_addr=0, go to Fetch.
- Fetch (2 cycles): cycle 1 presents addr 0; cycle 2 captures pixel_data, scales it, loads the shift register, enters Send. First bit starts on the cycle after capture.
- Scaling: each byte c -> (c*(brightness+1))>>8, 16-bit intermediate. brightness=255 gives identity; brightness=0 gives 0 for every c.
- Send: bits leave MSB first, G[7] first, then R, B, W. Each bit lasts exactly BIT_CLKS cycles; leds_line is high for the first T1H_CLKS ('1') or T0H_CLKS ('0') cycles, then low.
- Prefetch: when pixel k is loaded, pixel_addr becomes k+1 (if k<NUM_LEDS-1). pixel_data is captured into a prefetch buffer one cycle later. Pixel k+1 loads on the cycle pixel k's last bit ends, with no gap between pixels: total frame bit time = NUM_LEDS*8*BYTES_PER_LED*BIT_CLKS exactly.
- pixel_data is ignored except on capture cycles. The store must not change data for an address while it is being read.
- After the last bit of pixel NUM_LEDS-1: Latch, leds_line=0 for RESET_CLKS cycles. Then done=1 for one cycle, busy=0, pixel_addr=0, Idle.
- A start rising edge while busy is ignored (not queued). start held high through a frame does not retrigger; it must go low, then high.
- NUM_LEDS=1: no prefetch; pixel_addr stays 0.
- leds_line is a flop driven from the encoder compare. Its fixed 1-cycle offset from the internal bit counter is the only pipeline delay.

Decomposition:
- Package ws2812_pkg: state enum (IDLE, FETCH, SEND, LATCH); default timing localparams (63/39/19/2600); scaling helper function.
- Sub-module ws2812_bit_encoder: counts one bit period from a trigger plus bit value, drives the high/low compare, emits bit_end. It is parametrised by BIT_CLKS/T1H_CLKS/T0H_CLKS.
- The top level holds the FSM, shift register, prefetch buffer, bit/pixel counters and latch counter.

Test Plan:
- NUM_LEDS=2, RGB, brightness=255, pixels 0x800000 / 0x000001 -> bit 0 high 39 clks, bits 1..46 high 19 clks, bit 47 high 39 clks. Every period is 63 clks, then 2600 low, done pulse; busy high for 2+48*63+2600 cycles.
- BYTES_PER_LED=4, NUM_LEDS=1, pixel 0x0000_00FF, brightness=255 -> 24 '0' codes then 8 '1' codes; 32 bits total.
- brightness=127, pixel 0xFF8001 -> transmitted 0x7F4000; brightness=0 with 0xFFFFFF -> 24 '0' codes.
- start held high through and after the frame, plus a second edge mid-frame -> exactly one frame, one done. start low then high -> second frame.
- rst_n low during bit 10 of pixel 0 -> leds_line=0, busy=0 on the next clk. After release, no frame until a new start edge.
- Pixel store model with 1-cycle latency, NUM_LEDS=16, pixel k = k*0x010101 -> addresses 0..15 in order; decoded line matches; no inter-pixel gap.

Source files
------------

// File: rtl/ws2812_pkg.sv
// Shared types, default bit timing and the brightness scaling helper for the
// WS2812 chain driver.
package ws2812_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    LATCH = 2'd3
  } state_t;

  localparam int DEF_BIT_CLKS   = 63;
  localparam int DEF_T1H_CLKS   = 39;
  localparam int DEF_T0H_CLKS   = 19;
  localparam int DEF_RESET_CLKS = 2600;

  // Scale one colour byte by (brightness+1)/256; 255 is identity, 0 blanks.
  function automatic logic [7:0] scale_byte(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] prod;
    prod = 16'(c) * (16'(b) + 16'd1);
    return prod[15:8];
  endfunction

endpackage

// File: rtl/ws2812_bit_encoder.sv
// One NRZ bit period: counts BIT_CLKS cycles from a trigger and compares the
// count against the high time selected by the current bit value.
module ws2812_bit_encoder
  import ws2812_pkg::*;
#(
  parameter int BIT_CLKS = DEF_BIT_CLKS,
  parameter int T1H_CLKS = DEF_T1H_CLKS,
  parameter int T0H_CLKS = DEF_T0H_CLKS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic trigger,
  input  logic bit_val,
  output logic line_hi,
  output logic bit_end
);

  localparam int CNT_W = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIT_CLKS - 1);
  localparam logic [CNT_W-1:0] HI_ONE   = CNT_W'(T1H_CLKS);
  localparam logic [CNT_W-1:0] HI_ZERO  = CNT_W'(T0H_CLKS);

  logic [CNT_W-1:0] cnt;
  logic             active;

  // Bit-period counter; a trigger on the last cycle restarts it seamlessly.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      active <= 1'b0;
    end else if (trigger) begin
      cnt    <= '0;
      active <= 1'b1;
    end else if (bit_end) begin
      active <= 1'b0;
    end else if (active) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign bit_end = active && (cnt == LAST_CNT);
  assign line_hi = active && (cnt < (bit_val ? HI_ONE : HI_ZERO));

endmodule

// File: rtl/ws2812_chain_driver.sv
// Frame serialiser for a WS2812 strip: fetches pixels from a 1-cycle-latency
// store, scales them by a global brightness, shifts them out MSB first with
// one-pixel prefetch, then holds the latch gap and pulses done.
module ws2812_chain_driver
  import ws2812_pkg::*;
#(
  parameter  int NUM_LEDS      = 16,
  parameter  int BYTES_PER_LED = 3,
  parameter  int BIT_CLKS      = DEF_BIT_CLKS,
  parameter  int T1H_CLKS      = DEF_T1H_CLKS,
  parameter  int T0H_CLKS      = DEF_T0H_CLKS,
  parameter  int RESET_CLKS    = DEF_RESET_CLKS,
  localparam int ADDR_W        = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1,
  localparam int PIX_W         = 8 * BYTES_PER_LED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        brightness,
  output logic [ADDR_W-1:0] pixel_addr,
  input  logic [PIX_W-1:0]  pixel_data,
  output logic              busy,
  output logic              done,
  output logic              leds_line
);

  localparam int BIT_W = $clog2(PIX_W);
  localparam int LAT_W = (RESET_CLKS > 1) ? $clog2(RESET_CLKS) : 1;
  localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(PIX_W - 1);
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NUM_LEDS - 1);
  localparam logic [LAT_W-1:0]  LAST_LAT = LAT_W'(RESET_CLKS - 1);

  state_t            state, state_next;
  logic              start_q, start_rise, fetch_cnt;
  logic [7:0]        bright_q;
  logic [PIX_W-1:0]  shift_q, pf_buf, scaled;
  logic              pf_req, pf_cap;
  logic [BIT_W-1:0]  bit_idx;
  logic [ADDR_W-1:0] pix_idx, pix_inc;
  logic [LAT_W-1:0]  lat_cnt;
  logic              load_first, next_bit, next_pix, enter_latch, frame_end;
  logic              enc_trig, line_hi, bit_end;

  assign start_rise = start & ~start_q;
  assign pix_inc    = pix_idx + ADDR_W'(1);

  // Brightness-scaled view of the store output, used on capture cycles only.
  always_comb begin
    scaled = '0;
    for (int i = 0; i < BYTES_PER_LED; i++)
      scaled[8*i +: 8] = scale_byte(pixel_data[8*i +: 8], bright_q);
  end

  // The encoder reads the live MSB; the shift register advances on bit_end.
  ws2812_bit_encoder #(
    .BIT_CLKS (BIT_CLKS),
    .T1H_CLKS (T1H_CLKS),
    .T0H_CLKS (T0H_CLKS)
  ) u_enc (
    .clk     (clk),
    .rst_n   (rst_n),
    .trigger (enc_trig),
    .bit_val (shift_q[PIX_W-1]),
    .line_hi (line_hi),
    .bit_end (bit_end)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and per-cycle control strobes.
  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next  = state;
    load_first  = 1'b0;
    next_bit    = 1'b0;
    next_pix    = 1'b0;
    enter_latch = 1'b0;
    frame_end   = 1'b0;
    enc_trig    = 1'b0;
    case (state)
      IDLE: if (start_rise) state_next = FETCH;
      FETCH: if (fetch_cnt) begin
        load_first = 1'b1;
        enc_trig   = 1'b1;
        state_next = SEND;
      end
      SEND: if (bit_end) begin
        if (bit_idx != LAST_BIT) begin
          next_bit = 1'b1;
          enc_trig = 1'b1;
        end else if (pix_idx != LAST_PIX) begin
          next_pix = 1'b1;
          enc_trig = 1'b1;
        end else begin
          enter_latch = 1'b1;
          state_next  = LATCH;
        end
      end
      LATCH: if (lat_cnt == LAST_LAT) begin
        frame_end  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: handshake, shift register, prefetch pipeline and counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start_q    <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      leds_line  <= 1'b0;
      pixel_addr <= '0;
      fetch_cnt  <= 1'b0;
      bright_q   <= '0;
      shift_q    <= '0;
      pf_buf     <= '0;
      pf_req     <= 1'b0;
      pf_cap     <= 1'b0;
      bit_idx    <= '0;
      pix_idx    <= '0;
      lat_cnt    <= '0;
    end else begin
      start_q   <= start;
      done      <= frame_end;
      leds_line <= line_hi;
      pf_req    <= 1'b0;
      pf_cap    <= pf_req;
      if (pf_cap) pf_buf <= scaled;
      if (state == IDLE && start_rise) begin
        busy       <= 1'b1;
        bright_q   <= brightness;
        pixel_addr <= '0;
        fetch_cnt  <= 1'b0;
      end
      if (state == FETCH) fetch_cnt <= 1'b1;
      if (load_first) begin
        shift_q <= scaled;
        bit_idx <= '0;
        pix_idx <= '0;
        if (LAST_PIX != '0) begin
          pixel_addr <= ADDR_W'(1);
          pf_req     <= 1'b1;
        end
      end
      if (next_bit) begin
        shift_q <= {shift_q[PIX_W-2:0], 1'b0};
        bit_idx <= bit_idx + BIT_W'(1);
      end
      if (next_pix) begin
        shift_q <= pf_buf;
        bit_idx <= '0;
        pix_idx <= pix_inc;
        if (pix_inc != LAST_PIX) begin
          pixel_addr <= pix_inc + ADDR_W'(1);
          pf_req     <= 1'b1;
        end
      end
      if (enter_latch)         lat_cnt <= '0;
      else if (state == LATCH) lat_cnt <= lat_cnt + LAT_W'(1);
      if (frame_end) begin
        busy       <= 1'b0;
        pixel_addr <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ws2812_chain_driver.sv
// Bench for ws2812_chain_driver: three configurations (2-LED RGB, 1-LED RGBW,
// 16-LED RGB with short timing), each fed by a registered-read pixel store.
module tb_ws2812_chain_driver;

  localparam int A_BIT = 63, A_T1 = 39, A_T0 = 19, A_RST = 2600;
  localparam int C_BIT = 10, C_T1 = 6,  C_T0 = 3,  C_RST = 50;
  localparam int TR_MAX = 8192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Configuration A: 2 LEDs, GRB, default timing.
  logic        rst_n_a, start_a, busy_a, done_a, line_a;
  logic [7:0]  bright_a;
  logic [0:0]  addr_a;
  logic [23:0] data_a;
  logic [23:0] mem_a [0:1];
  always @(posedge clk) data_a <= mem_a[addr_a];

  // Configuration B: 1 LED, GRBW, default timing.
  logic        rst_n_b, start_b, busy_b, done_b, line_b;
  logic [7:0]  bright_b;
  logic [0:0]  addr_b;
  logic [31:0] data_b;
  logic [31:0] mem_b [0:0];
  always @(posedge clk) data_b <= mem_b[addr_b];

  // Configuration C: 16 LEDs, GRB, short timing.
  logic        rst_n_c, start_c, busy_c, done_c, line_c;
  logic [7:0]  bright_c;
  logic [3:0]  addr_c;
  logic [23:0] data_c;
  logic [23:0] mem_c [0:15];
  always @(posedge clk) data_c <= mem_c[addr_c];

  ws2812_chain_driver #(.NUM_LEDS(2), .BYTES_PER_LED(3), .BIT_CLKS(A_BIT),
    .T1H_CLKS(A_T1), .T0H_CLKS(A_T0), .RESET_CLKS(A_RST)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .start(start_a), .brightness(bright_a),
    .pixel_addr(addr_a), .pixel_data(data_a), .busy(busy_a), .done(done_a),
    .leds_line(line_a));

  ws2812_chain_driver #(.NUM_LEDS(1), .BYTES_PER_LED(4), .BIT_CLKS(A_BIT),
    .T1H_CLKS(A_T1), .T0H_CLKS(A_T0), .RESET_CLKS(A_RST)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .start(start_b), .brightness(bright_b),
    .pixel_addr(addr_b), .pixel_data(data_b), .busy(busy_b), .done(done_b),
    .leds_line(line_b));

  ws2812_chain_driver #(.NUM_LEDS(16), .BYTES_PER_LED(3), .BIT_CLKS(C_BIT),
    .T1H_CLKS(C_T1), .T0H_CLKS(C_T0), .RESET_CLKS(C_RST)) dut_c (
    .clk(clk), .rst_n(rst_n_c), .start(start_c), .brightness(bright_c),
    .pixel_addr(addr_c), .pixel_data(data_c), .busy(busy_c), .done(done_c),
    .leds_line(line_c));

  // Monitor mux selecting the configuration under test.
  int         sel;
  logic       mon_line, mon_busy, mon_done;
  logic [7:0] mon_addr;
  always_comb begin
    case (sel)
      0:       begin mon_line = line_a; mon_busy = busy_a; mon_done = done_a; mon_addr = 8'(addr_a); end
      1:       begin mon_line = line_b; mon_busy = busy_b; mon_done = done_b; mon_addr = 8'(addr_b); end
      default: begin mon_line = line_c; mon_busy = busy_c; mon_done = done_c; mon_addr = 8'(addr_c); end
    endcase
  end

  // Trace recorder, sampled on the falling edge.
  logic       rec_en;
  int         tr_n;
  logic       tr_line [TR_MAX];
  logic       tr_busy [TR_MAX];
  logic       tr_done [TR_MAX];
  logic [7:0] tr_addr [TR_MAX];
  always @(negedge clk) begin
    if (!rec_en) tr_n = 0;
    else if (tr_n < TR_MAX) begin
      tr_line[tr_n] = mon_line;
      tr_busy[tr_n] = mon_busy;
      tr_done[tr_n] = mon_done;
      tr_addr[tr_n] = mon_addr;
      tr_n = tr_n + 1;
    end
  end

  int   n_checks = 0;
  int   n_errors = 0;
  int   snap_n;
  logic exp_bits [512];
  int   exp_n;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add_word(input logic [31:0] w, input int width);
    for (int i = width - 1; i >= 0; i--) begin
      exp_bits[exp_n] = w[i];
      exp_n++;
    end
  endtask

  task automatic set_start(input int s, input logic v);
    case (s)
      0:       start_a = v;
      1:       start_b = v;
      default: start_c = v;
    endcase
  endtask

  // One start pulse, wait for done, record the whole frame.
  task automatic run_frame(input int s, input int budget, input string tag);
    int seen;
    @(posedge clk);
    rec_en = 1'b1;
    @(negedge clk);
    set_start(s, 1'b1);
    @(negedge clk);
    set_start(s, 1'b0);
    seen = 0;
    for (int i = 0; i < budget && seen == 0; i++) begin
      @(negedge clk);
      if (mon_done) seen = 1;
    end
    check({tag, " done reached"}, seen, 1);
    repeat (4) @(negedge clk);
    @(posedge clk);
    rec_en = 1'b0;
    snap_n = tr_n;
  endtask

  // Decode a recorded frame and compare it with exp_bits and the timing rules.
  task automatic analyze(input string tag, input int bitc, input int t1, input int t0,
                         input int rst_clks, input int n_pix);
    int b0, first_hi, busy_cnt, done_cnt, done_idx, exp_busy;
    int errs, bad, tail_hi, s, h, seq_n, seq_bad;
    logic [7:0] last;
    logic bad_bit, got;
    b0 = -1; first_hi = -1; busy_cnt = 0; done_cnt = 0; done_idx = -1;
    for (int i = 0; i < snap_n; i++) begin
      if (b0 < 0 && tr_busy[i]) b0 = i;
      if (first_hi < 0 && tr_line[i]) first_hi = i;
      if (tr_busy[i]) busy_cnt++;
      if (tr_done[i]) begin
        done_cnt++;
        if (done_idx < 0) done_idx = i;
      end
    end
    check({tag, " busy seen"}, (b0 >= 0), 1);
    if (b0 < 0) b0 = 0;
    exp_busy = 2 + exp_n * bitc + rst_clks;
    check({tag, " first-bit latency"}, first_hi - b0, 3);
    check({tag, " busy length"}, busy_cnt, exp_busy);
    check({tag, " done pulses"}, done_cnt, 1);
    check({tag, " done position"}, done_idx - b0, exp_busy);
    errs = 0; bad = 0;
    for (int b = 0; b < exp_n; b++) begin
      s = b0 + 3 + b * bitc;
      if (s + bitc > snap_n) begin
        bad++;
        continue;
      end
      h = 0;
      while (h < bitc && tr_line[s + h]) h++;
      bad_bit = (h != t1 && h != t0);
      for (int j = h; j < bitc; j++) if (tr_line[s + j]) bad_bit = 1'b1;
      if (bad_bit) bad++;
      got = (h == t1);
      if (got != exp_bits[b]) errs++;
    end
    check({tag, " bit value errors"}, errs, 0);
    check({tag, " bit timing errors"}, bad, 0);
    tail_hi = 0;
    for (int i = b0 + 3 + exp_n * bitc; i < snap_n; i++) if (tr_line[i]) tail_hi++;
    check({tag, " line high in latch gap"}, tail_hi, 0);
    seq_n = 1; seq_bad = (tr_addr[b0] != 8'd0) ? 1 : 0; last = tr_addr[b0];
    for (int i = b0 + 1; i < b0 + exp_busy && i < snap_n; i++) begin
      if (tr_addr[i] != last) begin
        if (tr_addr[i] != 8'(seq_n)) seq_bad++;
        seq_n++;
        last = tr_addr[i];
      end
    end
    check({tag, " address steps"}, seq_n, n_pix);
    check({tag, " address order errors"}, seq_bad, 0);
    if (done_idx >= 0) check({tag, " address after done"}, tr_addr[done_idx], 0);
  endtask

  typedef struct {
    logic [7:0]  bright;
    logic [23:0] p0, p1;
    logic [23:0] e0, e1;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int got, fin, dones, busy_after;
    vecs[0] = '{8'd255, 24'h800000, 24'h000001, 24'h800000, 24'h000001};
    vecs[1] = '{8'd127, 24'hFF8001, 24'h800000, 24'h7F4000, 24'h400000};
    vecs[2] = '{8'd0,   24'hFFFFFF, 24'hFFFFFF, 24'h000000, 24'h000000};
    vecs[3] = '{8'd255, 24'hA5C33C, 24'h0FF081, 24'hA5C33C, 24'h0FF081};
    vecs[4] = '{8'd200, 24'h64C8FF, 24'h102080, 24'h4E9DC8, 24'h0C1964};

    rst_n_a = 1'b0; rst_n_b = 1'b0; rst_n_c = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    bright_a = 8'd255; bright_b = 8'd255; bright_c = 8'd255;
    rec_en = 1'b0; sel = 0;
    mem_a[0] = '0; mem_a[1] = '0; mem_b[0] = '0;
    for (int k = 0; k < 16; k++) mem_c[k] = 24'(k * 24'h010101);

    repeat (3) @(negedge clk);
    rst_n_a = 1'b1; rst_n_b = 1'b1; rst_n_c = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check($sformatf("reset%0d line", s), mon_line, 0);
      check($sformatf("reset%0d busy", s), mon_busy, 0);
      check($sformatf("reset%0d done", s), mon_done, 0);
      check($sformatf("reset%0d addr", s), mon_addr, 0);
    end

    // Table-driven frames on configuration A.
    sel = 0;
    for (int v = 0; v < 5; v++) begin
      mem_a[0] = vecs[v].p0;
      mem_a[1] = vecs[v].p1;
      bright_a = vecs[v].bright;
      exp_n = 0;
      add_word(32'(vecs[v].e0), 24);
      add_word(32'(vecs[v].e1), 24);
      run_frame(0, 8000, $sformatf("vecA%0d", v));
      analyze($sformatf("vecA%0d", v), A_BIT, A_T1, A_T0, A_RST, 2);
    end

    // RGBW single pixel: 24 zero codes then 8 one codes.
    sel = 1;
    mem_b[0] = 32'h000000FF;
    bright_b = 8'd255;
    exp_n = 0;
    add_word(32'h000000FF, 32);
    run_frame(1, 8000, "rgbw");
    analyze("rgbw", A_BIT, A_T1, A_T0, A_RST, 1);

    // 16-pixel chain with prefetch and short timing.
    sel = 2;
    bright_c = 8'd255;
    exp_n = 0;
    for (int k = 0; k < 16; k++) add_word(32'(k * 32'h010101), 24);
    run_frame(2, 6000, "chain16");
    analyze("chain16", C_BIT, C_T1, C_T0, C_RST, 16);

    // start held through the frame plus a mid-frame edge: one frame only.
    sel = 0;
    mem_a[0] = 24'hFFFFFF; mem_a[1] = 24'h000000; bright_a = 8'd255;
    @(negedge clk);
    start_a = 1'b1;
    got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      @(negedge clk);
      if (mon_busy) got = 1;
    end
    check("held busy rise", got, 1);
    repeat (1000) @(negedge clk);
    start_a = 1'b0;
    @(negedge clk);
    start_a = 1'b1;
    dones = 0; fin = 0;
    for (int i = 0; i < 8000 && fin == 0; i++) begin
      @(negedge clk);
      if (mon_done) begin dones++; fin = 1; end
    end
    check("held frame done", fin, 1);
    busy_after = 0;
    repeat (300) begin
      @(negedge clk);
      if (mon_busy) busy_after++;
      if (mon_done) dones++;
    end
    check("held done count", dones, 1);
    check("held no retrigger", busy_after, 0);
    start_a = 1'b0;
    @(negedge clk);
    start_a = 1'b1;
    got = 0;
    for (int i = 0; i < 5 && got == 0; i++) begin
      @(negedge clk);
      if (mon_busy) got = 1;
    end
    check("second edge starts frame", got, 1);
    fin = 0;
    for (int i = 0; i < 8000 && fin == 0; i++) begin
      @(negedge clk);
      if (mon_done) fin = 1;
    end
    check("second frame done", fin, 1);
    start_a = 1'b0;

    // Reset in the middle of bit 10 of pixel 0.
    mem_a[0] = 24'hFFFFFF; mem_a[1] = 24'hFFFFFF;
    @(negedge clk);
    start_a = 1'b1;
    got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      @(negedge clk);
      if (mon_busy) got = 1;
    end
    check("rst test busy rise", got, 1);
    repeat (638) @(negedge clk);
    check("line high in bit 10", mon_line, 1);
    rst_n_a = 1'b0;
    @(negedge clk);
    check("mid-bit reset line", mon_line, 0);
    check("mid-bit reset busy", mon_busy, 0);
    check("mid-bit reset done", mon_done, 0);
    check("mid-bit reset addr", mon_addr, 0);
    rst_n_a = 1'b1;
    busy_after = 0;
    repeat (100) begin
      @(negedge clk);
      if (mon_busy) busy_after++;
    end
    check("no frame from held start", busy_after, 0);
    start_a = 1'b0;
    @(negedge clk);
    start_a = 1'b1;
    got = 0;
    for (int i = 0; i < 5 && got == 0; i++) begin
      @(negedge clk);
      if (mon_busy) got = 1;
    end
    check("new edge after reset", got, 1);
    rst_n_a = 1'b0;
    @(negedge clk);
    rst_n_a = 1'b1;
    start_a = 1'b0;
    @(negedge clk);
    check("final busy low", mon_busy, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
